keypad_event_decoder: RTL and testbench
=======================================

Name: keypad_event_decoder

Overview:
Reader side of the 4x4 keypad scan bus.
- Observes the active-low one-hot row drive produced by the keypad scanner, plus the active-low column returns.
- Debounces each of the 16 keys across full scans.
- Exports stable held levels, including the four paddle controls.
- Exports a buffered press/release event stream with a valid/ready handshake.
- Sits between the keypad scanner and the game logic; replaces ad-hoc combinational row/col decoding in the top level.

Parameters:
- SETTLE_CYC, 16: cycles after a row change before columns are trusted. Must be >= 4.
- DEBOUNCE_SCANS, 3: consecutive disagreeing scans required to flip a key's stable state. Range 1..15.
- EVT_DEPTH, 4: event FIFO depth. Must be a power of 2 and >= 2.

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- keypad_row  in  4  row drive from scanner; active-low one-hot
- keypad_col  in  4  column return from keypad; active-low; asynchronous
- key_held  out  16  debounced state; bit k=1 means key k is down
- up1  out  1  key_held[15]
- down1  out  1  key_held[3]
- up2  out  1  key_held[12]
- down2  out  1  key_held[0]
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts the head event
- evt_code  out  4  head event key index
- evt_press  out  1  head event kind: 1=press, 0=release
- evt_overflow  out  1  sticky flag: an event was dropped

Behaviour:
Clock and reset:
- Single clock domain, clk_50MHz. Reset is synchronous and active-high.
- On reset: key_held=0, all debounce counters=0, FIFO empty, evt_valid=0, evt_code=0, evt_press=0, evt_overflow=0, row_q=4'b1111, dwell counter=0, push FSM in IDLE.

Key indexing:
- Row index r = position of the 0 bit in keypad_row. Column index c = position of the 0 bit in keypad_col.
- Key index k = 4*r + c.
- Examples: row 0111 / col 0111 gives k=15 (up1); row 1110 / col 0111 gives k=3 (down1).

Column sampling:
- keypad_col passes through a 2-FF synchronizer, producing col_sync.
- row_q registers keypad_row every cycle.
- Dwell counter: cleared when keypad_row != row_q; otherwise increments, saturating at SETTLE_CYC.
- While dwell == SETTLE_CYC, col_hold <= col_sync each cycle. col_hold therefore holds the last settled sample of the current row.

Commit:
- A commit occurs on the cycle keypad_row != row_q, provided row_q is one-hot-low and dwell == SETTLE_CYC.
- The commit applies ~col_hold to the 4 keys of row_q.
- If row_q is invalid (not one-hot-low) or the dwell was short, no commit occurs and the row is silently skipped.

Debounce (per committed key):
- raw == stable: counter cleared to 0.
- raw != stable: counter increments. When it reaches DEBOUNCE_SCANS, the counter clears, stable flips, and the key's change bit is set.
- key_held updates the cycle after the commit.

Push FSM:
- States: IDLE and PUSH(c), c = 0..3.
- IDLE -> PUSH0 when a commit produces a non-zero change mask. The mask and row are latched at this point.
- Each PUSH(c) lasts 1 cycle. If change bit c is set, it pushes event {k=4r+c, press=new stable}.
- After PUSH3, return to IDLE. Events from one commit are therefore emitted in ascending column order within 4 cycles.
- SETTLE_CYC >= 4 guarantees no new commit arrives while the FSM is in PUSH.

Event FIFO:
- Show-ahead: evt_code and evt_press reflect the head entry whenever evt_valid=1.
- Pop occurs on evt_valid & evt_ready.
- Push when full with no pop in the same cycle: the event is dropped and evt_overflow=1 until reset.
- Push when full with a pop in the same cycle: the push is accepted.
- Push and pop when empty: the push is accepted; evt_valid rises the next cycle. There is no fall-through bypass.

Reset mid-operation:
- Reset aborts the push FSM, empties the FIFO, and clears all state.
- The first commit after reset requires a full settled dwell.

Latency:
- From the raw column sample becoming stable to the held flip: DEBOUNCE_SCANS scans of that row, plus 1 cycle.
- From the held flip to evt_valid: at most 5 cycles when the FIFO is empty.

Decomposition:
- keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=4.
  - Key index constants KEY_UP1=15, KEY_DOWN1=3, KEY_UP2=12, KEY_DOWN2=0.
  - Event record fields: code[3:0], press.
  - The one-hot-low validity/encode function.
- Sub-module keypad_evt_fifo: parameterised synchronous FIFO (5-bit entries, EVT_DEPTH deep), with count, full/empty, and the overflow flag.
- Synchronizer, dwell counter, debounce array and push FSM stay in the top of this block.

Test Plan:
Common setup: SETTLE_CYC=4, DEBOUNCE_SCANS=3; the bench scanner steps rows 0111, 1011, 1101, 1110 with 8 cycles per row.
1. Reset then idle (col=1111, 10 scans) -> key_held=0, evt_valid never asserts, evt_overflow=0.
2. Hold col=0111 only during row 0111 for 3 scans -> key_held[15]=1 and up1=1 after the 3rd row-0111 commit; one event {code=15, press=1}. Release for 3 scans -> up1=0; event {15, 0}.
3. Bounce: col=0111 during row 0111 for 2 scans, 1111 for 1 scan, 0111 for 3 scans -> exactly one press event, issued at scan 6.
4. Simultaneous: col=0000 during row 1110 for 3 scans -> events 0, 1, 2, 3 (all press=1) in ascending order over 4 consecutive cycles; down2=1.
5. Backpressure: evt_ready=0, generate 5 press events -> FIFO holds 4, evt_overflow=1. Then evt_ready=1 -> 4 pops, evt_valid drops, evt_overflow stays 1.
6. Glitches: row=1001 (invalid) for 8 cycles, or a 2-cycle row dwell -> no commit; key_held unchanged. Assert reset during PUSH1 -> evt_valid=0 and key_held=0 the following cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad event decoder.
//   - Keypad geometry and the key indices of the four paddle controls.
//   - The event record carried by the event FIFO.
//   - The push FSM state type.
//   - Helpers that validate and encode an active-low one-hot row/column vector.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam int unsigned KEY_UP1   = 15;
    localparam int unsigned KEY_DOWN1 = 3;
    localparam int unsigned KEY_UP2   = 12;
    localparam int unsigned KEY_DOWN2 = 0;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } evt_t;

    typedef enum logic [2:0] {
        StIdle,
        StPush0,
        StPush1,
        StPush2,
        StPush3
    } push_state_e;

    // True when exactly one bit of v is low.
    function automatic logic onehot_low_valid(input logic [3:0] v);
        return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
    endfunction

    // Position of the low bit; only meaningful when onehot_low_valid(v).
    function automatic logic [1:0] onehot_low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_event_decoder_if.sv
// keypad_event_decoder_if: key event stream with a valid/ready handshake.
//   valid : head event present (producer -> consumer)
//   ready : consumer accepts the head event (consumer -> producer)
//   code  : key index of the head event
//   press : 1 = press, 0 = release
interface keypad_event_decoder_if;

    logic       valid;
    logic       ready;
    logic [3:0] code;
    logic       press;

    modport master (
        output valid,
        output code,
        output press,
        input  ready
    );

    modport slave (
        input  valid,
        input  code,
        input  press,
        output ready
    );

endinterface

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: show-ahead synchronous FIFO for key events.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (dropped if full and not popping this cycle)
//   push_data  : event to enqueue
//   pop        : remove the head entry (ignored when empty)
//   head       : head entry, zero when empty
//   valid      : FIFO non-empty
//   overflow   : sticky, set when a push was dropped
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output evt_t head,
    output logic valid,
    output logic overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    evt_t        mem [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic [AW:0] count;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_q - rd_q;
    assign valid   = count != '0;
    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = count[AW];
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keypad_event_decoder.sv
// keypad_event_decoder: reader side of the 4x4 keypad scan bus.
//   clk_50MHz    : system clock
//   reset        : synchronous active-high reset
//   keypad_row   : scanner row drive, active-low one-hot
//   keypad_col   : keypad column return, active-low, asynchronous
//   key_held     : debounced key levels, bit k = key k down
//   up1/down1/up2/down2 : paddle controls (keys 15, 3, 12, 0)
//   evt_overflow : sticky, an event was dropped
//   evt          : press/release event stream (master side)
module keypad_event_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYC     = 16,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned EVT_DEPTH      = 4
) (
    input  logic                          clk_50MHz,
    input  logic                          reset,
    input  logic [3:0]                    keypad_row,
    input  logic [3:0]                    keypad_col,
    output logic [NUM_KEYS-1:0]           key_held,
    output logic                          up1,
    output logic                          down1,
    output logic                          up2,
    output logic                          down2,
    output logic                          evt_overflow,
    keypad_event_decoder_if.master        evt
);

    localparam int unsigned DW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SETTLE_CYC);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]                   col_meta;
    logic [3:0]                   col_sync;
    logic [3:0]                   col_hold;
    logic [3:0]                   row_q;
    logic [DW-1:0]                dwell_q;
    logic                         row_change;
    logic                         settled;
    logic                         commit;
    logic [1:0]                   row_idx;

    logic [NUM_KEYS-1:0]          held_q;
    logic [NUM_KEYS-1:0]          held_d;
    logic [NUM_KEYS-1:0][CW-1:0]  cnt_q;
    logic [NUM_KEYS-1:0][CW-1:0]  cnt_d;
    logic [3:0]                   chg_row;
    logic [3:0]                   kk;
    logic                         raw;

    push_state_e                  state_q;
    push_state_e                  state_d;
    logic [3:0]                   mask_q;
    logic [1:0]                   prow_q;
    logic                         fifo_push;
    logic [1:0]                   push_col;
    evt_t                         push_evt;
    evt_t                         head;
    logic                         fifo_valid;

    // Column sampling: synchronise the columns and only trust them once the
    // row has dwelt SETTLE_CYC cycles; col_hold keeps the last settled sample.
    assign row_change = keypad_row != row_q;
    assign settled    = dwell_q == DWELL_MAX;
    assign commit     = row_change && settled && onehot_low_valid(row_q);
    assign row_idx    = onehot_low_index(row_q);

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            col_hold <= 4'hF;
            row_q    <= 4'hF;
            dwell_q  <= '0;
        end else begin
            col_meta <= keypad_col;
            col_sync <= col_meta;
            row_q    <= keypad_row;
            if (row_change)    dwell_q <= '0;
            else if (!settled) dwell_q <= dwell_q + 1'b1;
            if (settled) col_hold <= col_sync;
        end
    end

    // Debounce the four keys of the committed row.
    always_comb begin
        held_d  = held_q;
        cnt_d   = cnt_q;
        chg_row = '0;
        kk      = '0;
        raw     = 1'b0;
        if (commit) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                kk  = {row_idx, 2'(c)};
                raw = ~col_hold[c];
                if (raw == held_q[kk]) begin
                    cnt_d[kk] = '0;
                end else if (cnt_q[kk] == DEB_LAST) begin
                    cnt_d[kk]  = '0;
                    held_d[kk] = raw;
                    chg_row[c] = 1'b1;
                end else begin
                    cnt_d[kk] = cnt_q[kk] + 1'b1;
                end
            end
        end
    end

    // Push FSM: one cycle per column, emitting only the columns that changed.
    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
        push_col  = 2'd0;
        unique case (state_q)
            StIdle:  if (commit && (chg_row != 4'd0)) state_d = StPush0;
            StPush0: begin push_col = 2'd0; fifo_push = mask_q[0]; state_d = StPush1; end
            StPush1: begin push_col = 2'd1; fifo_push = mask_q[1]; state_d = StPush2; end
            StPush2: begin push_col = 2'd2; fifo_push = mask_q[2]; state_d = StPush3; end
            StPush3: begin push_col = 2'd3; fifo_push = mask_q[3]; state_d = StIdle;  end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            held_q  <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
            mask_q  <= '0;
            prow_q  <= '0;
        end else begin
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (state_q == StIdle && commit && (chg_row != 4'd0)) begin
                mask_q <= chg_row;
                prow_q <= row_idx;
            end
        end
    end

    // held_q already carries the new stable level while in PUSH.
    assign push_evt.code  = {prow_q, push_col};
    assign push_evt.press = held_q[{prow_q, push_col}];

    keypad_evt_fifo #(
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk       (clk_50MHz),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_evt),
        .pop       (fifo_valid && evt.ready),
        .head      (head),
        .valid     (fifo_valid),
        .overflow  (evt_overflow)
    );

    assign evt.valid = fifo_valid;
    assign evt.code  = head.code;
    assign evt.press = head.press;

    assign key_held = held_q;
    assign up1      = held_q[KEY_UP1];
    assign down1    = held_q[KEY_DOWN1];
    assign up2      = held_q[KEY_UP2];
    assign down2    = held_q[KEY_DOWN2];

endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb_keypad_event_decoder: directed bench for keypad_event_decoder.
// The bench scans rows 0111, 1011, 1101, 1110 at 8 cycles per row and models
// the keypad as a 16-bit 'pressed' vector; events popped are logged at negedge.
module tb_keypad_event_decoder;
    import keypad_pkg::*;

    logic        clk_50MHz = 1'b0;
    logic        reset;
    logic [3:0]  keypad_row;
    logic [3:0]  keypad_col;
    logic [15:0] key_held;
    logic        up1, down1, up2, down2;
    logic        evt_overflow;

    logic [15:0] pressed;
    logic [3:0]  glitch_col;
    logic        valid_seen;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [4:0]  ev_q[$];
    int          ev_t[$];

    keypad_event_decoder_if evt_if ();

    keypad_event_decoder #(
        .SETTLE_CYC     (4),
        .DEBOUNCE_SCANS (3),
        .EVT_DEPTH      (4)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .keypad_row   (keypad_row),
        .keypad_col   (keypad_col),
        .key_held     (key_held),
        .up1          (up1),
        .down1        (down1),
        .up2          (up2),
        .down2        (down2),
        .evt_overflow (evt_overflow),
        .evt          (evt_if)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Keypad model: the driven row returns the pressed keys of that row.
    always_comb begin
        case (keypad_row)
            4'b0111: keypad_col = ~pressed[15:12];
            4'b1011: keypad_col = ~pressed[11:8];
            4'b1101: keypad_col = ~pressed[7:4];
            4'b1110: keypad_col = ~pressed[3:0];
            default: keypad_col = glitch_col;
        endcase
    end

    always @(negedge clk_50MHz) begin
        if (evt_if.valid === 1'b1) valid_seen = 1'b1;
        if (evt_if.valid === 1'b1 && evt_if.ready === 1'b1) begin
            ev_q.push_back({evt_if.code, evt_if.press});
            ev_t.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic step_row(input logic [3:0] row, input int n);
        keypad_row = row;
        tick(n);
    endtask

    task automatic run_scans(input int n);
        for (int s = 0; s < n; s++) begin
            step_row(4'b0111, 8);
            step_row(4'b1011, 8);
            step_row(4'b1101, 8);
            step_row(4'b1110, 8);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        keypad_row = 4'hF;
        pressed = '0;
        evt_if.ready = 1'b1;
        tick(2);
        reset = 1'b0;
        ev_q.delete();
        ev_t.delete();
        valid_seen = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (key_held !== 16'h0) begin bad++; $display("FAIL reset_held: got %h want 0000", key_held); end
        total++; if (evt_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_if.valid); end
        total++; if (evt_if.code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", evt_if.code); end
        total++; if (evt_if.press !== 1'b0) begin bad++; $display("FAIL reset_press: got %b want 0", evt_if.press); end
        total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", evt_overflow); end
        total++; if ({up1, down1, up2, down2} !== 4'b0) begin bad++; $display("FAIL reset_paddles: got %b want 0000", {up1, down1, up2, down2}); end
    endtask

    task automatic test_idle();
        do_reset();
        run_scans(10);
        total++; if (key_held !== 16'h0) begin bad++; $display("FAIL idle_held: got %h want 0000", key_held); end
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL idle_valid_seen: got %b want 0", valid_seen); end
        total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL idle_ovf: got %b want 0", evt_overflow); end
    endtask

    task automatic test_press_release();
        do_reset();
        pressed[15] = 1'b1;
        run_scans(2);
        total++; if (up1 !== 1'b0) begin bad++; $display("FAIL pr_early_up1: got %b want 0", up1); end
        run_scans(1);
        total++; if (key_held !== 16'h8000) begin bad++; $display("FAIL pr_held: got %h want 8000", key_held); end
        total++; if (up1 !== 1'b1) begin bad++; $display("FAIL pr_up1: got %b want 1", up1); end
        total++; if (ev_q.size() != 1 || ev_q[0] !== 5'h1F) begin bad++; $display("FAIL pr_press_evt: got n=%0d first=%h want n=1 first=1f", ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : 5'h0); end
        pressed[15] = 1'b0;
        run_scans(3);
        total++; if (up1 !== 1'b0) begin bad++; $display("FAIL pr_release_up1: got %b want 0", up1); end
        total++; if (ev_q.size() != 2 || ev_q[1] !== 5'h1E) begin bad++; $display("FAIL pr_release_evt: got n=%0d want n=2 second=1e", ev_q.size()); end
    endtask

    task automatic test_bounce();
        do_reset();
        pressed[15] = 1'b1;
        run_scans(2);
        pressed[15] = 1'b0;
        run_scans(1);
        pressed[15] = 1'b1;
        run_scans(2);
        total++; if (ev_q.size() != 0) begin bad++; $display("FAIL bounce_early_evt: got n=%0d want 0", ev_q.size()); end
        total++; if (key_held !== 16'h0) begin bad++; $display("FAIL bounce_early_held: got %h want 0000", key_held); end
        run_scans(1);
        total++; if (ev_q.size() != 1 || ev_q[0] !== 5'h1F) begin bad++; $display("FAIL bounce_evt: got n=%0d want n=1 first=1f", ev_q.size()); end
        total++; if (key_held !== 16'h8000) begin bad++; $display("FAIL bounce_held: got %h want 8000", key_held); end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp;
        do_reset();
        pressed = 16'h000F;
        run_scans(3);
        total++; if (ev_q.size() != 0) begin bad++; $display("FAIL sim_early_evt: got n=%0d want 0", ev_q.size()); end
        run_scans(1);
        total++; if (key_held !== 16'h000F) begin bad++; $display("FAIL sim_held: got %h want 000f", key_held); end
        total++; if (down2 !== 1'b1 || down1 !== 1'b1) begin bad++; $display("FAIL sim_paddles: got down2=%b down1=%b want 1 1", down2, down1); end
        total++; if (ev_q.size() != 4) begin bad++; $display("FAIL sim_count: got %0d want 4", ev_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {i[3:0], 1'b1};
            total++;
            if (ev_q.size() != 4 || ev_q[i] !== exp) begin
                bad++; $display("FAIL sim_evt%0d: got %h want %h", i, (ev_q.size() > i) ? ev_q[i] : 5'h0, exp);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (ev_t.size() != 4 || ev_t[i] != ev_t[i-1] + 1) begin
                bad++; $display("FAIL sim_gap%0d: got %0d want consecutive cycles", i, (ev_t.size() > i) ? ev_t[i] - ev_t[i-1] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        evt_if.ready = 1'b0;
        pressed = 16'h800F;
        run_scans(4);
        total++; if (evt_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf: got %b want 1", evt_overflow); end
        total++; if (evt_if.valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", evt_if.valid); end
        total++; if ({evt_if.code, evt_if.press} !== 5'h1F) begin bad++; $display("FAIL bp_head: got %h want 1f", {evt_if.code, evt_if.press}); end
        evt_if.ready = 1'b1;
        tick(8);
        total++; if (ev_q.size() != 4) begin bad++; $display("FAIL bp_pops: got %0d want 4", ev_q.size()); end
        total++; if (ev_q.size() != 4 || ev_q[0] !== 5'h1F || ev_q[1] !== 5'h01 || ev_q[2] !== 5'h03 || ev_q[3] !== 5'h05) begin
            bad++; $display("FAIL bp_order: got n=%0d want 1f 01 03 05", ev_q.size());
        end
        total++; if (evt_if.valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got %b want 0", evt_if.valid); end
        total++; if (evt_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky: got %b want 1", evt_overflow); end
    endtask

    task automatic test_glitch();
        do_reset();
        glitch_col = 4'b0000;
        pressed = 16'h8000;
        run_scans(2);
        step_row(4'b1001, 8);
        step_row(4'b0111, 2);
        step_row(4'b1011, 8);
        step_row(4'b1101, 8);
        step_row(4'b1110, 8);
        total++; if (key_held !== 16'h0) begin bad++; $display("FAIL glitch_held: got %h want 0000", key_held); end
        total++; if (ev_q.size() != 0) begin bad++; $display("FAIL glitch_evt: got n=%0d want 0", ev_q.size()); end
        run_scans(1);
        total++; if (key_held !== 16'h8000) begin bad++; $display("FAIL glitch_after_held: got %h want 8000", key_held); end
    endtask

    task automatic test_reset_mid_push();
        do_reset();
        pressed = 16'h000F;
        run_scans(3);
        keypad_row = 4'b0111;
        tick(1);
        tick(1);
        total++; if (key_held !== 16'h000F || evt_if.valid !== 1'b1) begin
            bad++; $display("FAIL mid_pre: got held=%h valid=%b want 000f 1", key_held, evt_if.valid);
        end
        reset = 1'b1;
        tick(1);
        total++; if (evt_if.valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", evt_if.valid); end
        total++; if (key_held !== 16'h0) begin bad++; $display("FAIL mid_held: got %h want 0000", key_held); end
        reset = 1'b0;
        valid_seen = 1'b0;
        tick(6);
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL mid_abort: got valid_seen=%b want 0", valid_seen); end
    endtask

    initial begin
        reset = 1'b1;
        keypad_row = 4'hF;
        pressed = '0;
        glitch_col = 4'hF;
        valid_seen = 1'b0;
        evt_if.ready = 1'b1;
        tick(1);
        test_reset();
        test_idle();
        test_press_release();
        test_bounce();
        test_simultaneous();
        test_backpressure();
        test_glitch();
        test_reset_mid_push();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
